// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the register-file write port between the in-order
// pipeline (A) and long-latency returns (B), and keeps the pending-write scoreboard.
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rstf,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  output logic [31:0]     busy,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_value,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_value,
  output logic            we,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rdValue,
  output logic [3:0]      starve_cnt
);

  localparam int unsigned CW = 4;
  localparam int unsigned AW = 5;

  logic            grant_a;
  logic            grant_b;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_value;
  logic [31:0]     busy_next;
  logic [CW-1:0]   starve_next;

  // A has priority unless B has lost STARVE_LIMIT cycles in a row
  always_comb begin
    grant_b   = b_valid && (!a_valid || (starve_cnt == CW'(STARVE_LIMIT)));
    grant_a   = a_valid && !grant_b;
    win_rd    = grant_b ? b_rd : a_rd;
    win_value = grant_b ? b_value : a_value;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign stall = ((rs1 != '0) && busy[rs1]) || ((rs2 != '0) && busy[rs2]);

  // Set beats clear on the same register: the issuing instruction is the newer producer
  always_comb begin
    busy_next = busy;
    if (we) begin
      busy_next[rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_comb begin
    starve_next = '0;
    if (b_valid && !grant_b) begin
      if (starve_cnt >= CW'(STARVE_LIMIT)) begin
        starve_next = CW'(STARVE_LIMIT);
      end else begin
        starve_next = starve_cnt + CW'(1);
      end
    end
  end

  // x0 writes are consumed but never reach the register file
  always_ff @(posedge clk or posedge rstf) begin
    if (rstf) begin
      we         <= 1'b0;
      rd         <= '0;
      rdValue    <= '0;
      busy       <= '0;
      starve_cnt <= '0;
    end else begin
      busy       <= busy_next;
      starve_cnt <= starve_next;
      if (grant_a || grant_b) begin
        we      <= (win_rd != '0);
        rd      <= win_rd;
        rdValue <= win_value;
      end else begin
        we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Source A: in-order pipeline writeback (ALU, JAL link, load data).
  - Source B: long-latency unit returns (multi-cycle load, future mul/div).
- Holds a pending-write scoreboard that drives the decode-stage stall for RAW hazards.
- Sits between the writeback stage and the register file. Output is registered; the register file commits on the edge where wb_we is high.

Parameters:
- XLEN, 32, data width of rdValue paths.
- STARVE_LIMIT, 4, consecutive lost cycles after which B takes priority; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rstf  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  decode issued an instruction that writes rd.
- issue_rd  in  5  destination of issued instruction.
- rs1  in  5  decode source 1.
- rs2  in  5  decode source 2.
- stall  out  1  RAW hazard on rs1/rs2; combinational from registered busy.
- busy  out  32  scoreboard bitmap; bit 0 always 0.
- a_valid  in  1  source A write request.
- a_ready  out  1  A granted this cycle.
- a_rd  in  5  A destination.
- a_value  in  XLEN  A write data.
- b_valid  in  1  source B write request.
- b_ready  out  1  B granted this cycle.
- b_rd  in  5  B destination.
- b_value  in  XLEN  B write data.
- we  out  1  register-file write enable (registered).
- rd  out  5  register-file write address (registered).
- rdValue  out  XLEN  register-file write data (registered).
- starve_cnt  out  4  debug view of starvation counter.

Behaviour:
- Reset (rstf high, async): we=0, rd=0, rdValue=0, busy=0, starve_cnt=0. Asserting reset mid-operation drops any granted-but-uncommitted write; nothing is written.
- Arbitration is combinational, with one grant per cycle.
  - Default priority is A over B.
  - If starve_cnt==STARVE_LIMIT and b_valid, B wins over A.
  - a_ready = grant_a; b_ready = grant_b. A transfer completes when valid&&ready.
  - ready never asserts without the matching valid.
- Output register, loaded at the edge after a grant:
  - rd and rdValue take the winner's values.
  - we=1 only if the winner's rd!=0; an x0 write is granted and consumed with we=0.
  - With no grant, we=0 and rd/rdValue hold their previous values.
  - Latency is one cycle from grant to we.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments on b_valid && !grant_b.
  - Clears on grant_b or when b_valid is low.
- Scoreboard:
  - Set busy[issue_rd] on issue_valid && issue_rd!=0.
  - Clear busy[rd] at the edge where we==1.
  - If set and clear hit the same register on the same edge, set wins (newer producer).
  - busy[0] is hard 0.
- stall = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]). There is no bypass; stall drops the cycle after the register file committed.
- Sources must not present a write for a register whose busy bit is clear; behaviour in that case is don't-care, but it must not corrupt other busy bits.
- Simultaneous a_valid and b_valid with equal rd: the arbitration order defines the write order. The later write overwrites; busy clears on the first commit. Decode must not issue such overlapping writes.

Test Plan:
- Reset mid-grant: a_valid, a_rd=5, a_value=0x11 granted, then rstf pulsed before the next edge -> we=0, busy=0, rdValue=0 after reset.
- Single A write: issue_rd=3, then a_valid, a_rd=3, a_value=0xDEADBEEF -> a_ready same cycle; next cycle we=1, rd=3, rdValue=0xDEADBEEF; busy[3] clears at that edge; stall for rs1=3 high until then, low after.
- x0 write: a_valid, a_rd=0, a_value=0x5 -> a_ready=1; next cycle we=0; busy unchanged.
- Contention and starvation (STARVE_LIMIT=4): a_valid and b_valid held high continuously -> A granted 4 cycles with starve_cnt 1,2,3,4; 5th cycle b_ready=1 and starve_cnt returns to 0; then A resumes.
- Set/clear collision: busy[7]=1 and a write to x7 committing (we=1, rd=7) while issue_valid with issue_rd=7 on the same edge -> busy[7] remains 1 and stall stays high for rs2=7.
- B alone: b_valid, b_rd=9, b_value=0x1234 with a_valid=0 -> b_ready immediately; we=1, rd=9 next cycle; starve_cnt stays 0.
